sort_mem_arbiter: RTL

- Round-robin arbiter that shares the single memory read/write handshake port of the sort accelerator among NUM_REQ sort-engine requesters.
- Each engine speaks the standard read_enable/read_ready/finish_read and write_enable/write_ready/finish_write protocol.
- The arbiter grants exclusive port ownership for a whole transaction, muxes the owner onto the memory side and gates ready back to the owner only.
- It also aggregates the engines' done flags.

---
 rtl/sort_mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sort_mem_arbiter.sv
// Round-robin arbiter sharing the sort accelerator memory read/write handshake port
// among NUM_REQ sort engines, with whole-transaction ownership and a one-cycle turnaround.
module sort_mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DSIZE   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_read_enable,
    input  logic [NUM_REQ-1:0]       req_write_enable,
    input  logic [NUM_REQ-1:0]       req_finish_read,
    input  logic [NUM_REQ-1:0]       req_finish_write,
    input  logic [NUM_REQ-1:0]       req_done,
    input  logic [NUM_REQ*DSIZE-1:0] req_read_addr,
    input  logic [NUM_REQ*DSIZE-1:0] req_read_size,
    input  logic [NUM_REQ*DSIZE-1:0] req_write_addr,
    input  logic [NUM_REQ*DSIZE-1:0] req_write_size,
    input  logic [NUM_REQ*DSIZE-1:0] req_write_data,
    output logic [NUM_REQ*DSIZE-1:0] req_read_ready,
    output logic [NUM_REQ*DSIZE-1:0] req_write_ready,
    output logic [DSIZE-1:0]         req_read_data,
    output logic                     mem_read_enable,
    output logic                     mem_write_enable,
    output logic                     mem_finish_read,
    output logic                     mem_finish_write,
    output logic [DSIZE-1:0]         mem_read_addr,
    output logic [DSIZE-1:0]         mem_read_size,
    output logic [DSIZE-1:0]         mem_write_addr,
    output logic [DSIZE-1:0]         mem_write_size,
    output logic [DSIZE-1:0]         mem_write_data,
    input  logic [DSIZE-1:0]         mem_read_ready,
    input  logic [DSIZE-1:0]         mem_write_ready,
    input  logic [DSIZE-1:0]         mem_read_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     all_done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    state_t               state_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [PW-1:0]        ptr_r;
    logic [PW-1:0]        owner_r;
    logic                 busy_r;
    logic                 all_done_r;
    logic [NUM_REQ-1:0]   request_s;
    logic [PW-1:0]        pick_idx_s;
    logic [NUM_REQ-1:0]   pick_onehot_s;
    logic                 own_s;
    logic                 release_s;

    // First requester at or after ptr, wrapping; scanning backwards lets the closest one win.
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [PW-1:0]      ptr);
        logic [PW-1:0] idx;
        logic [PW-1:0] cand;
        idx = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                idx = cand;
            end
        end
        return idx;
    endfunction

    assign request_s     = req_read_enable | req_write_enable;
    assign pick_idx_s    = rr_pick(request_s, ptr_r);
    assign pick_onehot_s = NUM_REQ'(1) << pick_idx_s;
    assign own_s         = (state_r == ST_OWN);

    // Owner release: both of its enables low while it holds the port.
    always_comb begin
        release_s = 1'b0;
        if (own_s) begin
            release_s = ~(req_read_enable[owner_r] | req_write_enable[owner_r]);
        end else begin
            release_s = 1'b0;
        end
    end

    // Arbitration FSM with registered grant, busy and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            ptr_r   <= '0;
            owner_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|request_s) begin
                        state_r <= ST_OWN;
                        grant_r <= pick_onehot_s;
                        owner_r <= pick_idx_s;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_OWN: begin
                    if (release_s) begin
                        state_r <= ST_DRAIN;
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                        ptr_r   <= (owner_r == LAST_IDX) ? '0 : owner_r + PW'(1);
                    end else begin
                        state_r <= ST_OWN;
                        busy_r  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Done aggregation, one cycle behind req_done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            all_done_r <= 1'b0;
        end else begin
            all_done_r <= &req_done;
        end
    end

    // AND-OR mux of the owner onto the memory side; ready is returned to the owner only.
    always_comb begin
        logic sel;
        sel              = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_finish_read  = 1'b0;
        mem_finish_write = 1'b0;
        mem_read_addr    = '0;
        mem_read_size    = '0;
        mem_write_addr   = '0;
        mem_write_size   = '0;
        mem_write_data   = '0;
        req_read_ready   = '0;
        req_write_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel              = own_s & grant_r[i];
            mem_read_enable  = mem_read_enable  | (sel & req_read_enable[i]);
            mem_write_enable = mem_write_enable | (sel & req_write_enable[i]);
            mem_finish_read  = mem_finish_read  | (sel & req_finish_read[i]);
            mem_finish_write = mem_finish_write | (sel & req_finish_write[i]);
            mem_read_addr    = mem_read_addr  | (req_read_addr[i*DSIZE +: DSIZE]  & {DSIZE{sel}});
            mem_read_size    = mem_read_size  | (req_read_size[i*DSIZE +: DSIZE]  & {DSIZE{sel}});
            mem_write_addr   = mem_write_addr | (req_write_addr[i*DSIZE +: DSIZE] & {DSIZE{sel}});
            mem_write_size   = mem_write_size | (req_write_size[i*DSIZE +: DSIZE] & {DSIZE{sel}});
            mem_write_data   = mem_write_data | (req_write_data[i*DSIZE +: DSIZE] & {DSIZE{sel}});
            req_read_ready[i*DSIZE +: DSIZE]  = mem_read_ready  & {DSIZE{sel}};
            req_write_ready[i*DSIZE +: DSIZE] = mem_write_ready & {DSIZE{sel}};
        end
    end

    assign req_read_data = mem_read_data;
    assign grant         = grant_r;
    assign busy          = busy_r;
    assign all_done      = all_done_r;

endmodule
